// File: rtl/gate_count_ctrl_pkg.sv
// Shared types and defaults for the gate/count sequencer: FSM state encoding,
// default gate length/timer width, and a single-digit BCD increment helper.
package gate_count_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam int unsigned GATE_CYCLES_DEF = 100000000;
    localparam int unsigned TW_DEF          = 27;

    // Returns {carry_out, digit}; a digit of 9 (or an illegal code) wraps to 0.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d, input logic cin);
        if (!cin) begin
            return {1'b0, d};
        end
        if (d >= 4'd9) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, d + 4'd1};
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for the asynchronous discriminator pulse followed by a
// registered rising-edge detector: one 1-clk strobe per edge, 3 clk after the rise.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic strobe_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic strobe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= pulse_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            strobe_q <= sync2_q & ~prev_q;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/gate_count_ctrl.sv
// Sequencer for the BCD dark-count counter: clear, gate for GATE_CYCLES clocks, latch
// result + sticky overflow, hand off via valid/ack. GATE_AUTO_RESTART_EN: ack loops to CLEAR.
module gate_count_ctrl
    import gate_count_ctrl_pkg::*;
#(
    parameter int unsigned Ndigit      = 8,
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned TW          = TW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pulse_in,
    output logic                  cnt_rst,
    output logic                  cnt_en,
    input  logic [4*Ndigit-1:0]   bcd_in,
    input  logic                  ovf_in,
    output logic [4*Ndigit-1:0]   data_out,
    output logic                  ovf_out,
    output logic                  valid,
    input  logic                  ack,
    output logic                  busy
);

    state_t               state_q;
    logic [TW-1:0]        timer_q;
    logic                 cnt_rst_q;
    logic                 cnt_en_q;
    logic [4*Ndigit-1:0]  data_q;
    logic [4*Ndigit-1:0]  data_d;
    logic                 ovf_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 strobe;

    pulse_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .pulse_i  (pulse_in),
        .strobe_o (strobe)
    );

    // The enable from the last gate slot is still pending when SETTLE hands over to
    // HOLD, so the captured value is the counter output plus that final increment.
    logic [4:0] dig;
    logic       carry;
    always_comb begin
        data_d = '0;
        dig    = '0;
        carry  = cnt_en_q;
        for (int unsigned i = 0; i < Ndigit; i++) begin
            dig                = bcd_digit_inc(bcd_in[4*i +: 4], carry);
            data_d[4*i +: 4]   = dig[3:0];
            carry              = dig[4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            cnt_rst_q <= 1'b1;
            cnt_en_q  <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_en_q <= strobe && (state_q == ST_GATE) && !abort;
            if ((state_q == ST_GATE || state_q == ST_SETTLE) && ovf_in && cnt_en_q) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_CLEAR;
                        cnt_rst_q <= 1'b1;
                        busy_q    <= 1'b1;
                        ovf_q     <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q   <= ST_GATE;
                        timer_q   <= TW'(GATE_CYCLES - 1);
                        cnt_rst_q <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        cnt_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (timer_q == '0) begin
                        state_q <= ST_SETTLE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        cnt_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        state_q <= ST_HOLD;
                        data_q  <= data_d;
                        valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (ack) begin
                        valid_q   <= 1'b0;
                        cnt_rst_q <= 1'b1;
`ifdef GATE_AUTO_RESTART_EN
                        state_q   <= ST_CLEAR;
                        ovf_q     <= 1'b0;
`else
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_rst_q <= 1'b1;
                    valid_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cnt_rst  = cnt_rst_q;
    assign cnt_en   = cnt_en_q;
    assign data_out = data_q;
    assign ovf_out  = ovf_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_gate_count_ctrl.sv
// Bench for gate_count_ctrl (GATE_CYCLES=20, Ndigit=2) with a behavioural 2-digit BCD
// counter wired to cnt_rst/cnt_en/bcd_in/ovf_in; honours GATE_AUTO_RESTART_EN if defined.
module tb_gate_count_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pulse_in;
    logic       cnt_rst;
    logic       cnt_en;
    logic [7:0] bcd_in;
    logic       ovf_in;
    logic [7:0] data_out;
    logic       ovf_out;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       preload_req;
    logic [7:0] cnt_q;

    gate_count_ctrl #(.Ndigit(2), .GATE_CYCLES(20), .TW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pulse_in (pulse_in),
        .cnt_rst  (cnt_rst),
        .cnt_en   (cnt_en),
        .bcd_in   (bcd_in),
        .ovf_in   (ovf_in),
        .data_out (data_out),
        .ovf_out  (ovf_out),
        .valid    (valid),
        .ack      (ack),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_bcd_inc(input logic [7:0] x);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = x[3:0];
        hi = x[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // Counter under control; preload_req jumps it to 98 to reach the wrap quickly.
    always_ff @(posedge clk) begin
        if (cnt_rst)          cnt_q <= 8'h00;
        else if (preload_req) cnt_q <= 8'h98;
        else if (cnt_en)      cnt_q <= tb_bcd_inc(cnt_q);
    end
    assign bcd_in = cnt_q;
    assign ovf_in = (cnt_q == 8'h99);

    typedef struct {
        int         r0;
        int         w;
        int         l;
        int         n;
        bit         pre;
        logic [7:0] ed;
        bit         eo;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    vec_t vt[9];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Pulse level during cycle c (cycle 0 follows the edge that samples start).
    function automatic bit lvl(input vec_t v, input int c);
        int p;
        if (c < v.r0 || v.n == 0) return 1'b0;
        p = v.w + v.l;
        if ((c - v.r0) / p >= v.n) return 1'b0;
        return ((c - v.r0) % p) < v.w;
    endfunction

    function automatic vec_t mkv(input int r0, input int w, input int l, input int n,
                                 input bit pre, input logic [7:0] ed, input bit eo);
        vec_t v;
        v.r0 = r0; v.w = w; v.l = l; v.n = n; v.pre = pre; v.ed = ed; v.eo = eo;
        return v;
    endfunction

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, {24'd0, data_out}, {24'd0, e.data});
            chk({tag, "_ovf"}, {31'd0, ovf_out}, {31'd0, e.ovf});
        end
    endtask

    // Entered/left just after a rising edge. cv = cycle in which valid is first seen.
    task automatic run_meas(input vec_t v, input string tag, output int cv);
        exp_t e;
        e.data = v.ed;
        e.ovf  = v.eo;
        sb.push_back(e);
        last_exp = e;
        cv = -1;
        for (int c = -4; c <= 30 && cv < 0; c++) begin
            pulse_in    = lvl(v, c);
            start       = (c == -1);
            preload_req = v.pre && (c == 2);
            @(negedge clk);
            if (c == -1) chk({tag, "_busy_pre"}, {31'd0, busy}, 32'd0);
            if (c == 0)  chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            if (valid) begin
                cv = c;
                pop_cmp(tag);
            end
            @(posedge clk); #1;
        end
        pulse_in = 1'b0; start = 1'b0; preload_req = 1'b0;
        chk({tag, "_valid_seen"}, {31'd0, cv >= 0}, 32'd1);
        chk({tag, "_valid_latency"}, cv, 32'd22);
    endtask

    // Stops a free-running loop that ack restarted.
    task automatic stop_loop(input string tag);
`ifdef GATE_AUTO_RESTART_EN
        chk({tag, "_restart_busy"}, {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk({tag, "_stopped"}, {31'd0, busy}, 32'd0);
`else
        chk({tag, "_idle_after_ack"}, {31'd0, busy}, 32'd0);
`endif
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk);
        chk({tag, "_valid_held"}, {31'd0, valid}, 32'd1);
        chk({tag, "_data_stable"}, {24'd0, data_out}, {24'd0, last_exp.data});
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_after_ack"}, {31'd0, valid}, 32'd0);
        stop_loop(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   cv;
        int   vseen;
        vec_t vr;
        vt[0] = mkv(-1, 2,  1, 7, 1'b0, 8'h07, 1'b0);
        vt[1] = mkv(-3, 2, 19, 2, 1'b0, 8'h00, 1'b0);
        vt[2] = mkv(-2, 2, 17, 2, 1'b0, 8'h02, 1'b0);
        vt[3] = mkv( 5, 3,  1, 1, 1'b0, 8'h01, 1'b0);
        vt[4] = mkv( 0, 2,  2, 2, 1'b1, 8'h00, 1'b1);
        vt[5] = mkv(14, 2,  1, 2, 1'b1, 8'h00, 1'b1);
        vt[6] = mkv( 5, 2,  2, 1, 1'b1, 8'h99, 1'b0);
        vt[7] = mkv( 0, 2,  1, 6, 1'b0, 8'h06, 1'b0);
        vt[8] = mkv( 0, 2,  1, 5, 1'b1, 8'h03, 1'b1);

        rst = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
        pulse_in = 1'b0; preload_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cnt_rst", {31'd0, cnt_rst}, 32'd1);
        chk("reset_cnt_en", {31'd0, cnt_en}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data", {24'd0, data_out}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_meas(vt[i], $sformatf("vec%0d", i), cv);
            do_ack($sformatf("vec%0d", i));
        end

        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack_valid", {31'd0, valid}, 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a gate with five pulses already counted.
        vr = mkv(0, 2, 1, 5, 1'b0, 8'h00, 1'b0);
        for (int c = -4; c <= 18; c++) begin
            pulse_in = lvl(vr, c);
            start    = (c == -1);
            @(negedge clk);
            if (c < 18) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0; pulse_in = 1'b0;
        chk("rst_mid_counted", {24'd0, cnt_q}, 32'h05);
        chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_cnt_rst", {31'd0, cnt_rst}, 32'd1);
        chk("rst_mid_cnt_en", {31'd0, cnt_en}, 32'd0);
        chk("rst_mid_data", {24'd0, data_out}, 32'd0);
        chk("rst_mid_ovf", {31'd0, ovf_out}, 32'd0);
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rel_valid", {31'd0, valid}, 32'd0);
        chk("rst_rel_busy", {31'd0, busy}, 32'd0);
        chk("rst_rel_counter", {24'd0, cnt_q}, 32'h00);
        @(posedge clk); #1;

        // Abort on the cycle the timer reaches zero.
        vr = mkv(0, 2, 1, 1, 1'b0, 8'h00, 1'b0);
        vseen = 0;
        for (int c = -4; c <= 30; c++) begin
            pulse_in = lvl(vr, c);
            start    = (c == -1);
            abort    = (c == 20);
            @(negedge clk);
            if (c == 20) chk("abort_busy_before", {31'd0, busy}, 32'd1);
            if (c == 21) begin
                chk("abort_busy_after", {31'd0, busy}, 32'd0);
                chk("abort_cnt_rst", {31'd0, cnt_rst}, 32'd1);
            end
            if (valid) vseen++;
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; pulse_in = 1'b0;
        chk("abort_no_valid", vseen, 32'd0);

        // start/abort ignored in HOLD; ack together with start ends in IDLE.
        run_meas(mkv(2, 2, 1, 3, 1'b0, 8'h03, 1'b0), "hold", cv);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("hold_start_valid", {31'd0, valid}, 32'd1);
        chk("hold_start_busy", {31'd0, busy}, 32'd1);
        chk("hold_start_data", {24'd0, data_out}, 32'h03);
        @(posedge clk); #1;
        ack = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("ack_start_valid", {31'd0, valid}, 32'd0);
        stop_loop("ack_start");
        @(posedge clk);
        @(negedge clk);
        chk("ack_start_not_queued", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

`ifdef GATE_AUTO_RESTART_EN
        // Back-to-back gate started by ack alone.
        run_meas(mkv(0, 2, 1, 2, 1'b0, 8'h02, 1'b0), "auto1", cv);
        sb.push_back('{data: 8'h00, ovf: 1'b0});
        last_exp = '{data: 8'h00, ovf: 1'b0};
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        @(negedge clk);
        chk("auto_clear_busy", {31'd0, busy}, 32'd1);
        cv = -1;
        for (int d = 1; d <= 40 && cv < 0; d++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                cv = d;
                pop_cmp("auto2");
            end
        end
        chk("auto2_latency", cv, 32'd22);
        @(posedge clk); #1;
        do_ack("auto2");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
